// File: rtl/ni_packet_injector_if.sv
// Packet-request, payload, credit and flit signals between a network-interface
// injector (master) and its environment / router local port (slave).
interface ni_packet_injector_if #(
  parameter int unsigned flit_size               = 1,
  parameter int unsigned phit_size               = 16,
  parameter int unsigned addr_length             = 10,
  parameter int unsigned no_vc                   = 4,
  parameter int unsigned floorplusone_log2_no_vc = 2,
  parameter int unsigned len_bits                = 4
);
  localparam int unsigned W = flit_size * phit_size;

  logic                               pkt_valid;
  logic                               pkt_ready;
  logic [addr_length-1:0]             pkt_dest;
  logic [len_bits-1:0]                pkt_len;
  logic [floorplusone_log2_no_vc-1:0] pkt_vc;
  logic                               payload_valid;
  logic                               payload_ready;
  logic [W-3:0]                       payload_data;
  logic [no_vc-1:0]                   credit_in;
  logic [W-1:0]                       flit_out;
  logic                               flit_valid;
  logic [floorplusone_log2_no_vc-1:0] flit_vc;
  logic                               busy;

  modport master (
    input  pkt_valid, pkt_dest, pkt_len, pkt_vc, payload_valid, payload_data, credit_in,
    output pkt_ready, payload_ready, flit_out, flit_valid, flit_vc, busy
  );

  modport slave (
    output pkt_valid, pkt_dest, pkt_len, pkt_vc, payload_valid, payload_data, credit_in,
    input  pkt_ready, payload_ready, flit_out, flit_valid, flit_vc, busy
  );
endinterface

// File: rtl/ni_packet_injector.sv
// Network-interface transmitter: turns packet requests plus a payload stream into
// head/body/tail flits, one per cycle, under per-VC credit-based flow control.
module ni_packet_injector #(
  parameter int unsigned flit_size               = 1,
  parameter int unsigned phit_size               = 16,
  parameter int unsigned addr_length             = 10,
  parameter int unsigned addr_place_in_header    = 0,
  parameter int unsigned no_vc                   = 4,
  parameter int unsigned floorplusone_log2_no_vc = 2,
  parameter int unsigned buffer_depth            = 4,
  parameter int unsigned len_bits                = 4
) (
  input logic                  clk,
  input logic                  reset,
  ni_packet_injector_if.master ni
);
  localparam int unsigned W  = flit_size * phit_size;
  localparam int unsigned CW = $clog2(buffer_depth + 1);

  localparam logic [len_bits-1:0] LenOne   = {{(len_bits-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       MaxCred  = CW'(buffer_depth);
  localparam logic [CW-1:0]       CredOne  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [no_vc-1:0]    VcOneHot = {{(no_vc-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

  state_e                             state_q, state_d;
  logic [addr_length-1:0]             dest_q;
  logic [len_bits-1:0]                len_q;
  logic [len_bits-1:0]                rem_q, rem_d;
  logic [floorplusone_log2_no_vc-1:0] vc_q;
  logic [CW-1:0]                      credit_q [no_vc];
  logic [CW-1:0]                      credit_d [no_vc];
  logic [W-1:0]                       flit_q, flit_d;
  logic                               flit_valid_q;
  logic [floorplusone_log2_no_vc-1:0] flit_vc_q;

  logic                accept;
  logic                send;
  logic                pay_take;
  logic                has_credit;
  logic [len_bits-1:0] len_eff;
  logic [W-1:0]        hdr;
  logic [no_vc-1:0]    take;

  assign len_eff    = (ni.pkt_len == '0) ? LenOne : ni.pkt_len;
  assign has_credit = (credit_q[vc_q] != '0);

  always_comb begin
    hdr = '0;
    hdr[W-1:W-2] = (len_q == LenOne) ? 2'b11 : 2'b01;
    hdr[W-3 -: len_bits] = len_q;
    hdr[addr_place_in_header+addr_length-1 -: addr_length] = dest_q;
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    accept   = 1'b0;
    send     = 1'b0;
    pay_take = 1'b0;
    flit_d   = '0;
    case (state_q)
      StIdle: begin
        if (ni.pkt_valid) begin
          accept  = 1'b1;
          rem_d   = len_eff;
          state_d = StHead;
        end
      end
      StHead: begin
        if (has_credit) begin
          send    = 1'b1;
          flit_d  = hdr;
          rem_d   = rem_q - LenOne;
          state_d = (len_q == LenOne) ? StIdle : StBody;
        end
      end
      StBody: begin
        // A body/tail word moves only when both payload and a downstream slot exist.
        if (ni.payload_valid && has_credit) begin
          pay_take = 1'b1;
          send     = 1'b1;
          flit_d   = {((rem_q == LenOne) ? 2'b10 : 2'b00), ni.payload_data};
          rem_d    = rem_q - LenOne;
          if (rem_q == LenOne) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign take = send ? (VcOneHot << vc_q) : '0;

  // Simultaneous send and return on one VC cancel; returns beyond full depth are dropped.
  always_comb begin
    for (int v = 0; v < int'(no_vc); v++) begin
      credit_d[v] = credit_q[v];
      if (ni.credit_in[v] && !take[v]) begin
        if (credit_q[v] != MaxCred) credit_d[v] = credit_q[v] + CredOne;
      end else if (take[v] && !ni.credit_in[v]) begin
        credit_d[v] = credit_q[v] - CredOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      dest_q       <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      vc_q         <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      flit_vc_q    <= '0;
      for (int v = 0; v < int'(no_vc); v++) credit_q[v] <= MaxCred;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      flit_valid_q <= send;
      credit_q     <= credit_d;
      if (accept) begin
        dest_q <= ni.pkt_dest;
        len_q  <= len_eff;
        vc_q   <= ni.pkt_vc;
      end
      if (send) begin
        flit_q    <= flit_d;
        flit_vc_q <= vc_q;
      end
    end
  end

  assign ni.pkt_ready     = (state_q == StIdle);
  assign ni.busy          = (state_q != StIdle);
  assign ni.payload_ready = pay_take;
  assign ni.flit_out      = flit_q;
  assign ni.flit_valid    = flit_valid_q;
  assign ni.flit_vc       = flit_vc_q;
endmodule
